// File: rtl/przesuniecie_lewo_sekw.sv
// Sequential signed left shifter.
// The shift amount arrives one's-complemented in i_arg_B (n = ~i_arg_B).
// A negative n is rejected with o_error. Otherwise the operand moves left
// one bit per clock for min(n, BITS) clocks, and overflow is tracked
// alongside. o_valid pulses for exactly one cycle when o_result and the
// flags are final.
module przesuniecie_lewo_sekw #(
    parameter int BITS = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic signed [BITS-1:0] i_arg_A,
    input  logic signed [BITS-1:0] i_arg_B,
    output logic signed [BITS-1:0] o_result,
    output logic                   o_valid,
    output logic                   o_busy,
    output logic                   o_error,
    output logic                   o_overflow
);

    localparam int               CNT_W  = $clog2(BITS + 1);
    localparam logic [BITS-1:0]  BITS_V = BITS'(BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q,    state_d;
    logic [BITS-1:0]   work_q,     work_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [BITS-1:0]   result_q,   result_d;
    logic              error_q,    error_d;
    logic              overflow_q, overflow_d;
    logic [BITS-1:0]   n_amt;

    // The decoded shift amount. Its MSB is the sign of n.
    assign n_amt = ~i_arg_B;

    // State register and datapath registers, with synchronous reset to all zeros.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values and the process order cannot matter.
        if (i_rst) begin
            state_q    <= IDLE;
            work_q     <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            error_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            error_q    <= error_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state and datapath logic: accept, shift one bit per clock, publish.
    always_comb begin
        // NOTE: every signal gets a hold-value default before the case statement,
        // so no path leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        error_d    = error_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    result_d   = '0;
                    overflow_d = 1'b0;
                    if (n_amt[BITS-1]) begin
                        // A negative amount is rejected immediately.
                        error_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        error_d = 1'b0;
                        work_d  = i_arg_A;
                        // Shifting more than BITS places gives the same result as BITS.
                        cnt_d   = (n_amt >= BITS_V) ? CNT_W'(BITS) : CNT_W'(n_amt);
                        state_d = SHIFT;
                    end
                end
            end

            SHIFT: begin
                if (cnt_q != '0) begin
                    // A sign change across the top two bits means the shifted
                    // value no longer fits in BITS signed bits.
                    if (work_q[BITS-1] != work_q[BITS-2]) begin
                        overflow_d = 1'b1;
                    end
                    work_d = {work_q[BITS-2:0], 1'b0};
                    cnt_d  = cnt_q - CNT_W'(1);
                end else begin
                    result_d = work_q;
                    state_d  = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_result   = result_q;
    assign o_error    = error_q;
    assign o_overflow = overflow_q;
    assign o_valid    = (state_q == DONE);
    assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_przesuniecie_lewo_sekw.sv
// Bench for przesuniecie_lewo_sekw (BITS = 32).
// An arithmetic reference model, built on edge numbers and 64-bit products,
// predicts every output on every cycle. Directed operations also pin
// literal results and latencies.
module tb_przesuniecie_lewo_sekw;

    localparam int BITS = 32;

    logic                   i_clk;
    logic                   i_rst;
    logic                   i_start;
    logic signed [BITS-1:0] i_arg_A;
    logic signed [BITS-1:0] i_arg_B;
    logic signed [BITS-1:0] o_result;
    logic                   o_valid;
    logic                   o_busy;
    logic                   o_error;
    logic                   o_overflow;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    przesuniecie_lewo_sekw #(.BITS(BITS)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_arg_A    (i_arg_A),
        .i_arg_B    (i_arg_B),
        .o_result   (o_result),
        .o_valid    (o_valid),
        .o_busy     (o_busy),
        .o_error    (o_error),
        .o_overflow (o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // An operation accepted at edge acc_e finishes at edge done_e:
    //   acc_e + 0      if n < 0,
    //   acc_e + m + 1  if n >= 0, where m = min(n, 32).
    // The block is busy between acc_e and done_e. It can accept again
    // from edge done_e + 2 onward.
    int          edge_no = 0;
    int          acc_e   = -100;
    int          done_e  = -100;
    logic [31:0] m_res, fin_res;
    bit          m_err, m_ovf, fin_err, fin_ovf;

    always @(posedge i_clk) begin
        int     n;
        int     m;
        longint prod;
        edge_no++;
        if (i_rst) begin
            acc_e  = -100;
            done_e = -100;
            m_res  = '0;
            m_err  = 0;
            m_ovf  = 0;
        end else if (i_start && edge_no >= done_e + 2) begin
            n     = int'($signed(~i_arg_B));
            acc_e = edge_no;
            m_res = '0;
            m_err = 0;
            m_ovf = 0;
            if (n < 0) begin
                done_e  = edge_no;
                fin_res = '0;
                fin_err = 1;
                fin_ovf = 0;
            end else begin
                m       = (n > BITS) ? BITS : n;
                prod    = longint'(i_arg_A) <<< m;
                fin_res = prod[31:0];
                fin_err = 0;
                fin_ovf = (prod > 64'sd2147483647) || (prod < -64'sd2147483648);
                done_e  = edge_no + m + 1;
            end
        end
        if (!i_rst && edge_no == done_e) begin
            m_res = fin_res;
            m_err = fin_err;
            m_ovf = fin_ovf;
        end
    end

    // Compare outputs against the model on every falling edge.
    always @(negedge i_clk) begin
        bit e_busy;
        bit e_valid;
        if (chk_en) begin
            e_valid = (edge_no == done_e);
            e_busy  = (edge_no >= acc_e) && (edge_no <= done_e + 0) ? 1'b1 : 1'b0;
            // The DONE cycle also counts as busy.
            check("cmp_valid",  32'(o_valid),  32'(e_valid));
            check("cmp_busy",   32'(o_busy),   32'(e_busy));
            check("cmp_result", o_result,      m_res);
            check("cmp_error",  32'(o_error),  32'(m_err));
            // Sticky overflow may rise part-way through a shift; compare only when final.
            if (!e_busy || e_valid) check("cmp_overflow", 32'(o_overflow), 32'(m_ovf));
        end
    end

    // ---------------- directed stimulus ----------------
    // Called one time unit after a rising edge with the DUT idle. The task
    // starts an operation, waits (bounded) for o_valid, and checks literals.
    // It returns one time unit after the edge that enters DONE.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input bit exp_ovf, input bit exp_err,
                          input int exp_lat, input bit inject);
        int lat;
        i_arg_A = a;
        i_arg_B = b;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        lat     = 1;
        // Changing the arguments after acceptance must not affect the result.
        i_arg_A = 32'h1234_5678;
        i_arg_B = 32'hFFFF_FFFE;
        while (!o_valid && lat < 100) begin
            @(posedge i_clk); #1;
            lat++;
            if (inject && lat == 2) begin
                i_start = 1'b1;
                i_arg_A = 32'd9;
            end else begin
                i_start = 1'b0;
            end
        end
        i_start = 1'b0;
        check({name, "_valid"},    32'(o_valid),    32'd1);
        check({name, "_lat"},      32'(lat),        32'(exp_lat));
        check({name, "_result"},   o_result,        exp_res);
        check({name, "_overflow"}, 32'(o_overflow), 32'(exp_ovf));
        check({name, "_error"},    32'(o_error),    32'(exp_err));
    endtask

    task automatic next_idle();
        @(posedge i_clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_arg_A = '0;
        i_arg_B = '0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst  = 1'b0;
        chk_en = 1;

        // State after reset
        check("rst_result",   o_result,         32'd0);
        check("rst_valid",    32'(o_valid),     32'd0);
        check("rst_busy",     32'(o_busy),      32'd0);
        check("rst_error",    32'(o_error),     32'd0);
        check("rst_overflow", 32'(o_overflow),  32'd0);

        // Basic shift and overflow boundaries
        run_op("a5_n3",    32'd5,          ~32'd3, 32'd40,        0, 0, 5, 0);  next_idle();
        run_op("ovf_n1",   32'h4000_0000,  ~32'd1, 32'h8000_0000, 1, 0, 3, 0);  next_idle();
        run_op("neg_n1",   32'hC000_0000,  ~32'd1, 32'h8000_0000, 0, 0, 3, 0);  next_idle();
        run_op("err",      32'd123,        32'h0,  32'd0,         0, 1, 1, 0);  next_idle();
        run_op("n0",       -32'sd7,        32'hFFFF_FFFF, -32'sd7, 0, 0, 2, 0); next_idle();
        run_op("n40_a1",   32'd1,          ~32'd40, 32'd0,        1, 0, 34, 0); next_idle();
        run_op("n40_a0",   32'd0,          ~32'd40, 32'd0,        0, 0, 34, 0); next_idle();
        run_op("n32_a3",   32'd3,          ~32'd32, 32'd0,        1, 0, 34, 0); next_idle();
        run_op("n31_a1",   32'd1,          ~32'd31, 32'h8000_0000, 1, 0, 33, 0); next_idle();
        run_op("n30_am1",  32'hFFFF_FFFF,  ~32'd30, 32'hC000_0000, 0, 0, 32, 0);

        // Results hold after DONE
        repeat (4) @(posedge i_clk);
        #1;
        check("hold_result", o_result, 32'hC000_0000);
        check("hold_busy",   32'(o_busy), 32'd0);

        // Reset aborts an operation part-way through SHIFT
        i_arg_A = 32'd1;
        i_arg_B = ~32'd10;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        check("abort_busy",   32'(o_busy),     32'd0);
        check("abort_valid",  32'(o_valid),    32'd0);
        check("abort_result", o_result,        32'd0);
        check("abort_ovf",    32'(o_overflow), 32'd0);
        run_op("post_abort", 32'd3, ~32'd2, 32'd12, 0, 0, 4, 0); next_idle();

        // A start asserted together with reset is dropped
        i_rst   = 1'b1;
        i_start = 1'b1;
        i_arg_B = ~32'd2;
        @(posedge i_clk); #1;
        i_rst   = 1'b0;
        i_start = 1'b0;
        check("rst_start_busy", 32'(o_busy), 32'd0);
        @(posedge i_clk); #1;
        check("rst_start_idle", 32'(o_busy), 32'd0);

        // A start during SHIFT is ignored; a back-to-back start after DONE is accepted
        run_op("ignored", 32'd2, ~32'd5, 32'd64, 0, 0, 7, 1); next_idle();
        run_op("b2b",     32'd7, ~32'd1, 32'd14, 0, 0, 3, 0);

        repeat (3) @(posedge i_clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
